// File: rtl/calibrate_bank.sv
// calibrate_bank: a bank of CHANNELS unsigned calibration values.
// Push-buttons step the selected channel up or down with saturation, and a held
// button auto-repeats. A clear switch reloads one channel or all channels.
// All values are presented in parallel on a flat bus.
module calibrate_bank #(
  parameter int CHANNELS      = 2,
  parameter int SEL_W         = 1,
  parameter int WIDTH         = 8,
  parameter int STEP          = 1,
  parameter int INIT_VALUE    = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                      i_clock,
  input  logic                      i_resetn,
  input  logic                      i_inc_n,
  input  logic                      i_dec_n,
  input  logic                      i_clr,
  input  logic                      i_clr_all,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [CHANNELS*WIDTH-1:0] o_values,
  output logic                      o_upd,
  output logic                      o_sat,
  output logic [2:0]                o_current_state
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_STEP       = 3'd1;
  localparam logic [2:0] S_HOLD       = 3'd2;
  localparam logic [2:0] S_CLEAR      = 3'd3;
  localparam logic [2:0] S_CLEAR_WAIT = 3'd4;

  localparam logic [WIDTH-1:0] L_INIT     = WIDTH'(INIT_VALUE);
  localparam logic [WIDTH:0]   L_STEP     = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   L_MAX      = {1'b0, {WIDTH{1'b1}}};
  localparam logic [31:0]      L_DLY_LOAD = (REPEAT_DELAY >= 2) ? 32'(REPEAT_DELAY - 2) : 32'd0;
  localparam logic [31:0]      L_PER_LOAD = (REPEAT_PERIOD >= 2) ? 32'(REPEAT_PERIOD - 2) : 32'd0;
  localparam logic             L_RPT_EN   = (REPEAT_DELAY != 0);

  logic             r_inc_s1, r_inc_s2, r_dec_s1, r_dec_s2, r_clr_s1, r_clr_s2;
  logic [2:0]       r_state;
  logic             r_dir;
  logic             r_rpt;
  logic [SEL_W-1:0] r_ch;
  logic [31:0]      r_cnt;
  logic [WIDTH-1:0] r_vals [CHANNELS];
  logic             r_upd, r_sat;

  logic             w_inc, w_dec, w_own_alone;
  logic [WIDTH-1:0] w_cur;
  logic             w_ch_ok, w_sel_ok;
  logic [WIDTH:0]   w_res;

  // Saturating step at WIDTH+1 bits; MSB of the result flags a clamp
  // (which also covers a value already sitting at the limit).
  function automatic logic [WIDTH:0] step_value(input logic [WIDTH-1:0] v, input logic up);
    logic [WIDTH:0] ext;
    logic [WIDTH:0] res;
    ext = {1'b0, v};
    if (up) begin
      if ((ext + L_STEP) > L_MAX) res = {1'b1, L_MAX[WIDTH-1:0]};
      else                        res = {1'b0, v + L_STEP[WIDTH-1:0]};
    end else begin
      if (ext < L_STEP) res = {1'b1, {WIDTH{1'b0}}};
      else              res = {1'b0, v - L_STEP[WIDTH-1:0]};
    end
    return res;
  endfunction

  assign w_inc       = ~r_inc_s2;
  assign w_dec       = ~r_dec_s2;
  assign w_own_alone = r_dir ? (w_inc & ~w_dec) : (w_dec & ~w_inc);

  // Select the latched channel's value and flag whether ch / sel name a real channel.
  always_comb begin
    w_cur    = '0;
    w_ch_ok  = 1'b0;
    w_sel_ok = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_ch == SEL_W'(i)) begin
        w_cur   = r_vals[i];
        w_ch_ok = 1'b1;
      end
      if (i_sel == SEL_W'(i)) w_sel_ok = 1'b1;
    end
  end

  assign w_res = step_value(w_cur, r_dir);

  // Two-flop synchronizers for the asynchronous buttons and clear switch.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_inc_s1 <= 1'b1;
      r_inc_s2 <= 1'b1;
      r_dec_s1 <= 1'b1;
      r_dec_s2 <= 1'b1;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
    end else begin
      r_inc_s1 <= i_inc_n;
      r_inc_s2 <= r_inc_s1;
      r_dec_s1 <= i_dec_n;
      r_dec_s2 <= r_dec_s1;
      r_clr_s1 <= i_clr;
      r_clr_s2 <= r_clr_s1;
    end
  end

  // Control FSM: key press, hold with auto-repeat countdown, and clear handshake.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_rpt   <= 1'b0;
      r_ch    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_clr_s2) begin
            r_state <= S_CLEAR;
          end else if (w_inc ^ w_dec) begin
            r_state <= S_STEP;
            r_dir   <= w_inc;
            r_ch    <= i_sel;
            r_rpt   <= 1'b0;
          end
        end
        S_STEP: begin
          r_state <= S_HOLD;
          r_cnt   <= r_rpt ? L_PER_LOAD : L_DLY_LOAD;
        end
        S_HOLD: begin
          if (!w_inc && !w_dec) begin
            r_state <= S_IDLE;
          end else if (w_own_alone) begin
            // Opposite key held freezes the countdown by skipping this branch.
            if (r_cnt == 32'd0) begin
              if (L_RPT_EN) begin
                r_state <= S_STEP;
                r_rpt   <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 32'd1;
            end
          end
        end
        S_CLEAR:      r_state <= S_CLEAR_WAIT;
        S_CLEAR_WAIT: if (!r_clr_s2) r_state <= S_IDLE;
        default:      r_state <= S_IDLE;
      endcase
    end
  end

  // Value storage plus one-cycle update/saturation pulses.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < CHANNELS; i++) r_vals[i] <= L_INIT;
      r_upd <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      r_sat <= 1'b0;
      if (r_state == S_STEP && w_ch_ok) begin
        for (int i = 0; i < CHANNELS; i++)
          if (r_ch == SEL_W'(i)) r_vals[i] <= w_res[WIDTH-1:0];
        r_upd <= (w_res[WIDTH-1:0] != w_cur);
        r_sat <= w_res[WIDTH];
      end else if (r_state == S_CLEAR) begin
        if (i_clr_all) begin
          for (int i = 0; i < CHANNELS; i++) r_vals[i] <= L_INIT;
          r_upd <= 1'b1;
        end else if (w_sel_ok) begin
          for (int i = 0; i < CHANNELS; i++)
            if (i_sel == SEL_W'(i)) r_vals[i] <= L_INIT;
          r_upd <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign o_values[g*WIDTH +: WIDTH] = r_vals[g];
  end

  assign o_upd           = r_upd;
  assign o_sat           = r_sat;
  assign o_current_state = r_state;

endmodule

// File: tb/tb_calibrate_bank.sv
// Testbench for calibrate_bank: directed sequence with randomized channel,
// direction and hold lengths, checked against a schedule-based reference model.
module tb_calibrate_bank;

  localparam int CH   = 3;
  localparam int SW   = 2;
  localparam int W    = 8;
  localparam int STP  = 3;
  localparam int INIT = 16;
  localparam int D    = 10;
  localparam int P    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            inc_n = 1'b1;
  logic            dec_n = 1'b1;
  logic            clr = 1'b0;
  logic            clr_all = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [CH*W-1:0] values;
  logic            upd, sat;
  logic [2:0]      state;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_v [CH];

  calibrate_bank #(
    .CHANNELS(CH), .SEL_W(SW), .WIDTH(W), .STEP(STP), .INIT_VALUE(INIT),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .i_clock(clk), .i_resetn(resetn), .i_inc_n(inc_n), .i_dec_n(dec_n),
    .i_clr(clr), .i_clr_all(clr_all), .i_sel(sel),
    .o_values(values), .o_upd(upd), .o_sat(sat), .o_current_state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < CH; c++) chk(tag, 32'(values[c*W +: W]), 32'(exp_v[c]));
  endtask

  // Reference arithmetic: clamp v +/- STEP into [0, MAXV].
  function automatic int m_step(input int v, input bit up, output bit s);
    int n;
    n = up ? v + STP : v - STP;
    s = (n > MAXV) || (n < 0);
    if (n > MAXV) n = MAXV;
    if (n < 0)    n = 0;
    return n;
  endfunction

  // Press one key for n cycles (optionally adding the opposite key after opp_m
  // cycles) and check every cycle against the expected change schedule:
  // first change 3 edges after the press, then D later, then every P.
  task automatic hold_key(input bit up, input int ch, input int n, input int opp_m);
    int  next_t, steps, nv;
    bit  s, eu, es, live;
    sel = ch[SW-1:0];
    if (up) inc_n = 1'b0; else dec_n = 1'b0;
    next_t = 3;
    steps  = 0;
    live   = 1'b1;
    for (int k = 1; k <= n + 8; k++) begin
      if (k - 1 == n) begin inc_n = 1'b1; dec_n = 1'b1; end
      if (opp_m >= 0 && k - 1 == opp_m) begin
        if (up) dec_n = 1'b0; else inc_n = 1'b0;
      end
      tick();
      eu = 1'b0;
      es = 1'b0;
      if (live && (k - 1) == next_t) begin
        if (next_t <= n + 2 && (opp_m < 0 || next_t <= opp_m + 2)) begin
          if (ch < CH) begin
            nv = m_step(exp_v[ch], up, s);
            eu = (nv != exp_v[ch]);
            es = s;
            exp_v[ch] = nv;
          end
          steps++;
          next_t += (steps == 1) ? D : P;
        end else begin
          live = 1'b0;
        end
      end
      if (k - 1 == 2) chk("hold_state_step", 32'(state), 32'd1);
      if (k - 1 == 3) chk("hold_state_hold", 32'(state), 32'd2);
      if (ch < CH) chk("hold_value", 32'(values[ch*W +: W]), 32'(exp_v[ch]));
      chk("hold_upd", 32'(upd), 32'(eu));
      chk("hold_sat", 32'(sat), 32'(es));
    end
    chk("hold_end_state", 32'(state), 32'd0);
    check_all("hold_end_vals");
  endtask

  initial begin
    for (int c = 0; c < CH; c++) exp_v[c] = INIT;

    // Reset state
    tick();
    tick();
    check_all("reset_vals");
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_upd", 32'(upd), 32'd0);
    chk("reset_sat", 32'(sat), 32'd0);
    #3 resetn = 1'b1;
    tick();

    // Single step on channel 1
    hold_key(1'b1, 1, 5, -1);

    // Randomized short presses, including the out-of-range select
    for (int r = 0; r < 8; r++)
      hold_key(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(5, 8)), -1);

    // Long holds: repeat timing and saturation at both ends
    hold_key(1'b1, 0, 300, -1);
    hold_key(1'b0, 1, 300, -1);
    hold_key(1'b1, 3, 30, -1);

    // Opposite key mid-hold freezes the value
    hold_key(1'b0, 0, 40, 18);

    // Single-channel clear, keys ignored in CLEAR_WAIT
    hold_key(1'b1, 2, 5, -1);
    sel = 2'd2;
    clr_all = 1'b0;
    clr = 1'b1;
    repeat (3) tick();
    chk("clr_state_clear", 32'(state), 32'd3);
    check_all("clr_pre_vals");
    tick();
    exp_v[2] = INIT;
    check_all("clr_one_vals");
    chk("clr_one_upd", 32'(upd), 32'd1);
    chk("clr_one_sat", 32'(sat), 32'd0);
    chk("clr_wait_state", 32'(state), 32'd4);
    inc_n = 1'b0;
    repeat (8) tick();
    check_all("clr_wait_keys_vals");
    chk("clr_wait_keys_state", 32'(state), 32'd4);
    chk("clr_wait_keys_upd", 32'(upd), 32'd0);
    inc_n = 1'b1;
    clr = 1'b0;
    repeat (6) tick();
    chk("clr_release_state", 32'(state), 32'd0);

    // Clear with an out-of-range select does nothing
    hold_key(1'b0, 0, 5, -1);
    sel = 2'd3;
    clr = 1'b1;
    repeat (4) tick();
    check_all("clr_oor_vals");
    chk("clr_oor_upd", 32'(upd), 32'd0);
    chk("clr_oor_state", 32'(state), 32'd4);
    clr = 1'b0;
    repeat (6) tick();

    // Clear-all
    hold_key(1'b1, 1, 5, -1);
    sel = 2'd0;
    clr_all = 1'b1;
    clr = 1'b1;
    repeat (4) tick();
    for (int c = 0; c < CH; c++) exp_v[c] = INIT;
    check_all("clr_all_vals");
    chk("clr_all_upd", 32'(upd), 32'd1);
    clr = 1'b0;
    repeat (6) tick();
    clr_all = 1'b0;
    chk("clr_all_idle", 32'(state), 32'd0);

    // Asynchronous reset in the middle of a hold
    sel = 2'd0;
    inc_n = 1'b0;
    repeat (6) tick();
    chk("rst_pre_hold", 32'(state), 32'd2);
    chk("rst_pre_val", 32'(values[0 +: W]), 32'(INIT + STP));
    #2 resetn = 1'b0;
    #1;
    for (int c = 0; c < CH; c++) exp_v[c] = INIT;
    check_all("rst_async_vals");
    chk("rst_async_state", 32'(state), 32'd0);
    #2 resetn = 1'b1;
    tick();
    chk("rst_rel_e0_state", 32'(state), 32'd0);
    tick();
    chk("rst_rel_e1_state", 32'(state), 32'd0);
    tick();
    chk("rst_rel_e2_state", 32'(state), 32'd1);
    tick();
    exp_v[0] = INIT + STP;
    check_all("rst_rel_step_vals");
    chk("rst_rel_step_upd", 32'(upd), 32'd1);
    inc_n = 1'b1;
    repeat (8) tick();
    chk("rst_final_state", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
